// File: rtl/seq_11011_gen.sv
// Serial burst generator: sends PATTERN MSB-first reps times, with gap idle
// cycles between repetitions, then pulses done. All outputs are registered.
//
// state | meaning
// IDLE  | waiting for start with nonzero reps
// SEND  | shifting out pattern bits, idx counts down to 0
// GAP   | zero-bit spacing between repetitions, gap_cnt counts down
// DONE  | one-cycle done pulse after the last repetition
module seq_11011_gen #(
  parameter logic [4:0] PATTERN = 5'b11011,
  parameter int         PLEN    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] reps,
  input  logic [2:0] gap,
  output logic       out,
  output logic       valid,
  output logic       busy,
  output logic       done,
  output logic [3:0] rep_cnt
);

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  localparam logic [2:0] IDX_TOP = 3'(PLEN - 1);

  state_t     state, state_nxt;
  logic [2:0] idx, idx_nxt;
  logic [3:0] reps_q, reps_nxt;
  logic [2:0] gap_q, gap_nxt;
  logic [2:0] gap_cnt, gap_cnt_nxt;
  logic [3:0] rep_cnt_nxt;
  logic       out_nxt, valid_nxt, busy_nxt, done_nxt;
  logic       last_rep;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      reps_q  <= '0;
      gap_q   <= '0;
      gap_cnt <= '0;
      rep_cnt <= '0;
      out     <= 1'b0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      reps_q  <= reps_nxt;
      gap_q   <= gap_nxt;
      gap_cnt <= gap_cnt_nxt;
      rep_cnt <= rep_cnt_nxt;
      out     <= out_nxt;
      valid   <= valid_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
    end
  end

  // Compare with >= so rep_cnt can never run past the latched count.
  assign last_rep = ({1'b0, rep_cnt} + 5'd1) >= {1'b0, reps_q};

  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    reps_nxt    = reps_q;
    gap_nxt     = gap_q;
    gap_cnt_nxt = gap_cnt;
    rep_cnt_nxt = rep_cnt;
    out_nxt     = 1'b0;
    valid_nxt   = 1'b0;
    busy_nxt    = 1'b0;
    done_nxt    = 1'b0;
    if (abort) begin
      state_nxt   = IDLE;
      idx_nxt     = '0;
      gap_cnt_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && (reps != 4'd0)) begin
            state_nxt   = SEND;
            reps_nxt    = reps;
            gap_nxt     = gap;
            rep_cnt_nxt = '0;
            idx_nxt     = IDX_TOP;
            out_nxt     = PATTERN[IDX_TOP];
            valid_nxt   = 1'b1;
            busy_nxt    = 1'b1;
          end
        end
        SEND: begin
          busy_nxt = 1'b1;
          if (idx != 3'd0) begin
            idx_nxt   = idx - 3'd1;
            out_nxt   = PATTERN[idx - 3'd1];
            valid_nxt = 1'b1;
          end else begin
            rep_cnt_nxt = rep_cnt + 4'd1;
            if (last_rep) begin
              state_nxt = DONE;
              busy_nxt  = 1'b0;
              done_nxt  = 1'b1;
            end else if (gap_q != 3'd0) begin
              state_nxt   = GAP;
              gap_cnt_nxt = gap_q;
            end else begin
              idx_nxt   = IDX_TOP;
              out_nxt   = PATTERN[IDX_TOP];
              valid_nxt = 1'b1;
            end
          end
        end
        GAP: begin
          busy_nxt = 1'b1;
          if (gap_cnt <= 3'd1) begin
            state_nxt   = SEND;
            gap_cnt_nxt = '0;
            idx_nxt     = IDX_TOP;
            out_nxt     = PATTERN[IDX_TOP];
            valid_nxt   = 1'b1;
          end else begin
            gap_cnt_nxt = gap_cnt - 3'd1;
          end
        end
        DONE: begin
          state_nxt = IDLE;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_11011_gen.sv
// Self-checking bench for seq_11011_gen: directed scenarios plus randomized
// bursts checked against a cycle-sequence reference model.
module tb_seq_11011_gen;

  logic       clk, rst, start, abort;
  logic [3:0] reps;
  logic [2:0] gap;
  logic       out, valid, busy, done;
  logic [3:0] rep_cnt;

  int total = 0;
  int bad   = 0;

  // expected per-cycle {busy, done, valid, out}
  logic [3:0] exp_q[$];

  seq_11011_gen dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .reps(reps), .gap(gap), .out(out), .valid(valid),
    .busy(busy), .done(done), .rep_cnt(rep_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic build_model(input int r, input int g);
    logic [4:0] pat;
    pat = 5'b11011;
    exp_q.delete();
    for (int k = 0; k < r; k++) begin
      for (int b = 4; b >= 0; b--) exp_q.push_back({1'b1, 1'b0, 1'b1, pat[b]});
      if (k < r - 1)
        for (int j = 0; j < g; j++) exp_q.push_back(4'b1000);
    end
    exp_q.push_back(4'b0100);
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; abort = 1'b0; reps = 4'd3; gap = 3'd1;
    repeat (2) @(negedge clk);
    total++;
    if ({out, valid, busy, done, rep_cnt} !== 8'h00) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=%b", {out, valid, busy, done, rep_cnt}, 8'h00);
    end
    start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({valid, busy} !== 2'b00) begin
      bad++;
      $display("FAIL reset_idle got=%b want=00", {valid, busy});
    end
  endtask

  task automatic test_single;
    logic [4:0] shreg;
    int nvalid;
    shreg = '0; nvalid = 0;
    start = 1'b1; reps = 4'd1; gap = 3'd0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      shreg = {shreg[3:0], out};
      if (valid === 1'b1) nvalid++;
      @(negedge clk);
    end
    total++;
    if (shreg !== 5'b11011 || nvalid != 5) begin
      bad++;
      $display("FAIL single_bits got=%b/%0d want=11011/5", shreg, nvalid);
    end
    total++;
    if ({done, valid, busy, rep_cnt} !== {3'b100, 4'd1}) begin
      bad++;
      $display("FAIL single_done got=%b want=%b", {done, valid, busy, rep_cnt}, {3'b100, 4'd1});
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL single_done_width got=%b want=0", done);
    end
  endtask

  task automatic test_random_bursts;
    int r, g, first_v, last_v;
    for (int n = 0; n < 12; n++) begin
      r = (n == 0) ? 3 : $urandom_range(1, 15);
      g = (n == 0) ? 2 : $urandom_range(0, 7);
      build_model(r, g);
      start = 1'b1; reps = 4'(r); gap = 3'(g);
      @(negedge clk);
      start = 1'b0;
      first_v = -1; last_v = -1;
      foreach (exp_q[i]) begin
        total++;
        if ({busy, done, valid, out} !== exp_q[i]) begin
          bad++;
          $display("FAIL burst%0d_cyc%0d r=%0d g=%0d got=%b want=%b",
                   n, i, r, g, {busy, done, valid, out}, exp_q[i]);
        end
        if (valid === 1'b1) begin
          if (first_v < 0) first_v = i;
          last_v = i;
        end
        // junk on the config inputs and stray starts must be ignored mid-burst
        reps  = 4'($urandom);
        gap   = 3'($urandom);
        start = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      start = 1'b0;
      total++;
      if (last_v - first_v + 1 != 5 * r + g * (r - 1) || rep_cnt !== 4'(r)) begin
        bad++;
        $display("FAIL burst%0d_len got=%0d/%0d want=%0d/%0d",
                 n, last_v - first_v + 1, rep_cnt, 5 * r + g * (r - 1), r);
      end
    end
  endtask

  task automatic test_detector;
    logic [4:0] hist;
    int nb, det, nbusy;
    hist = '0; nb = 0; det = 0; nbusy = 0;
    start = 1'b1; reps = 4'd2; gap = 3'd0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (busy === 1'b1) nbusy++;
      hist = {hist[3:0], out};
      nb++;
      if (nb >= 5 && hist == 5'b11011) begin
        det++;
        nb = 0;
      end
      @(negedge clk);
    end
    total++;
    if (det != 2 || nbusy != 10) begin
      bad++;
      $display("FAIL detector got=%0d/%0d want=2/10", det, nbusy);
    end
  endtask

  task automatic test_abort;
    int ndone;
    ndone = 0;
    start = 1'b1; reps = 4'd4; gap = 3'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    total++;
    if ({busy, valid, out} !== 3'b110) begin
      bad++;
      $display("FAIL abort_setup got=%b want=110", {busy, valid, out});
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++;
    if ({out, valid, busy, done, rep_cnt} !== {4'b0000, 4'd1}) begin
      bad++;
      $display("FAIL abort_idle got=%b want=%b", {out, valid, busy, done, rep_cnt}, {4'b0000, 4'd1});
    end
    for (int i = 0; i < 30; i++) begin
      if (done === 1'b1 || valid === 1'b1) ndone++;
      @(negedge clk);
    end
    total++;
    if (ndone != 0) begin
      bad++;
      $display("FAIL abort_quiet got=%0d want=0", ndone);
    end
  endtask

  task automatic test_ignored;
    int act;
    act = 0;
    start = 1'b1; reps = 4'd0; gap = 3'd2;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (busy === 1'b1 || valid === 1'b1 || done === 1'b1) act++;
      @(negedge clk);
    end
    total++;
    if (act != 0 || rep_cnt !== 4'd1) begin
      bad++;
      $display("FAIL reps_zero got=%0d/%0d want=0/1", act, rep_cnt);
    end
    start = 1'b1; abort = 1'b1; reps = 4'd5;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (busy === 1'b1 || valid === 1'b1 || done === 1'b1) act++;
      @(negedge clk);
    end
    total++;
    if (act != 0 || rep_cnt !== 4'd1) begin
      bad++;
      $display("FAIL start_abort got=%0d/%0d want=0/1", act, rep_cnt);
    end
  endtask

  task automatic test_rst_mid_gap;
    start = 1'b1; reps = 4'd2; gap = 3'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    total++;
    if ({busy, valid, rep_cnt} !== {2'b10, 4'd1}) begin
      bad++;
      $display("FAIL gap_setup got=%b want=%b", {busy, valid, rep_cnt}, {2'b10, 4'd1});
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({out, valid, busy, done, rep_cnt} !== 8'h00) begin
      bad++;
      $display("FAIL rst_mid_gap got=%b want=%b", {out, valid, busy, done, rep_cnt}, 8'h00);
    end
    rst = 1'b0; start = 1'b1; reps = 4'd1; gap = 3'd0;
    @(negedge clk);
    start = 1'b0;
    total++;
    if ({busy, valid, out} !== 3'b111) begin
      bad++;
      $display("FAIL start_after_rst got=%b want=111", {busy, valid, out});
    end
    for (int i = 0; i < 20 && done !== 1'b1; i++) @(negedge clk);
    total++;
    if (done !== 1'b1 || rep_cnt !== 4'd1) begin
      bad++;
      $display("FAIL rst_burst_done got=%b/%0d want=1/1", done, rep_cnt);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    start = 1'b1; reps = 4'd1; gap = 3'd0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20 && done !== 1'b1; i++) @(negedge clk);
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL b2b_first_done got=%b want=1", done);
    end
    @(negedge clk);
    start = 1'b1; reps = 4'd2; gap = 3'd1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if ({busy, valid, out, rep_cnt} !== {3'b111, 4'd0}) begin
      bad++;
      $display("FAIL b2b_accept got=%b want=%b", {busy, valid, out, rep_cnt}, {3'b111, 4'd0});
    end
    for (int i = 0; i < 40 && done !== 1'b1; i++) @(negedge clk);
    total++;
    if (done !== 1'b1 || rep_cnt !== 4'd2) begin
      bad++;
      $display("FAIL b2b_second_done got=%b/%0d want=1/2", done, rep_cnt);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_random_bursts();
    test_detector();
    test_abort();
    test_ignored();
    test_rst_mid_gap();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
